typed_stream_packer: RTL
========================

Name: typed_stream_packer

Overview:
- Packs a stream of typed scalar elements (one per cycle, up to 64 bits each) into full-width AXI4-Stream beats.
- Sits directly upstream of output_writer, which consumes the packed beats and writes them to a host buffer.
- Element width comes from a libstf type_t. UINT32_T elements pack 16 per beat; UINT64_T and DOUBLE elements pack 8 per beat.
- Partial final beats are flushed with tkeep masking and tlast.

Parameters:
- OUT_WIDTH, 512, output beat width in bits; must be a multiple of 64.
- IN_WIDTH, 64, input element bus width; fixed at 64, the widest type_t.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- data_type, in, 2 (libstf::type_t), element type of the stream; sampled at stream start.
- s_data, in, IN_WIDTH, element; UINT32_T uses bits [31:0] only.
- s_valid, in, 1, element valid.
- s_last, in, 1, final element of the stream.
- s_ready, out, 1, element accepted when s_valid && s_ready.
- m_tdata, out, OUT_WIDTH, packed beat.
- m_tkeep, out, OUT_WIDTH/8, byte enables.
- m_tlast, out, 1, final beat of the stream.
- m_tvalid, out, 1, beat valid.
- m_tready, in, 1, downstream ready.
- err_type, out, 1, sticky: an unknown data_type was sampled.

Behaviour:
- Reset (aresetn low, async):
  - m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, err_type=0.
  - Lane counter=0, stream-active=0, accumulator cleared.
  - Reset mid-stream discards the partial beat and any pending output beat.
- Type latch:
  - On the first accepted element of a stream (stream-active=0), data_type is latched and stream-active is set.
  - data_type changes are ignored until the element with s_last is accepted, which clears stream-active.
- Width:
  - W = GET_TYPE_WIDTH(latched type), 32 or 64.
  - Lanes per beat N = OUT_WIDTH/W.
  - Element k of a beat goes to m_tdata[k*W +: W]; the first element sits in the lowest lane.
- Unknown type (2'b11, W=0):
  - err_type set (sticky until reset).
  - All elements of that stream are accepted (s_ready=1) and discarded; no beats are emitted.
  - stream-active clears on s_last.
- Structure: accumulator register plus one output register.
  - s_ready = !m_tvalid || m_tready. This is a combinational path from m_tready and is intentional.
  - An accepted element fills lane count; count increments.
  - When count reaches N-1 or s_last=1, the completed word moves to the output register at the same edge.
  - Count resets to 0 and the accumulator clears.
- Output register load:
  - m_tvalid=1 the cycle after the completing element. Latency: 1 cycle.
  - m_tkeep = ones for bytes of lanes 0..count; zero above.
  - m_tlast = s_last of the completing element.
- Output hold rules:
  - m_tdata, m_tkeep and m_tlast are held stable while m_tvalid && !m_tready.
  - m_tvalid clears on m_tready unless a new beat loads in the same cycle.
- Throughput: one element per cycle sustained when m_tready=1.
- Simultaneous pop and load: the new beat replaces the old one in the same cycle, with no bubble.
- Full beats always carry all-ones tkeep.
- A stream whose element count is an exact multiple of N ends on a full beat with tlast=1; no extra empty beat.
- s_last on the first element produces a single beat with one lane kept.

Decomposition:
- Additions to package libstf:
  - function GET_TYPE_LANES(type_t, int out_width) returning N.
  - typedef for a packed-beat struct {data, keep, last} parameterised by the 512-bit default width.
- Reuse GET_TYPE_WIDTH.
- Natural sub-module: axis_beat_reg, a single-entry output register with valid/ready hold semantics.

Test Plan:
- UINT32_T, 16 elements 0..15, last on the 16th, m_tready=1 -> one beat, lane i=i, tkeep all ones, tlast=1, emitted 1 cycle after the 16th element.
- UINT64_T, 10 elements, last on the 10th -> beat 1 full (8 lanes, tlast=0); beat 2 has lanes 0-1 valid, tkeep=0x...FFFF in the low 16 bytes only, tlast=1.
- DOUBLE, 8 elements; m_tready held low 5 cycles after the beat appears -> s_ready=0 and m_tdata stable throughout; stream resumes after the pop with no element lost.
- data_type switched UINT32_T->UINT64_T mid-stream -> packing stays 32-bit until s_last; the next stream packs 64-bit.
- data_type=2'b11, 5 elements -> s_ready=1 throughout, no m_tvalid, err_type=1 and held.
- aresetn asserted after 3 UINT32_T elements with a beat pending -> m_tvalid=0 immediately; the following stream of 1 element emits tkeep=0xF, tlast=1.

Source files
------------

// File: rtl/typed_stream_packer_pkg.sv
// Shared types and helpers for the typed stream packer: element type codes,
// lane-width lookups and the packed-beat record used at the 512-bit default.
package typed_stream_packer_pkg;

  // Element type codes; 2'b11 is not a valid type and is treated as width 0.
  typedef enum logic [1:0] {
    UINT32_T = 2'd0,
    UINT64_T = 2'd1,
    DOUBLE   = 2'd2
  } type_t;

  localparam int BEAT_W = 512;

  // One packed output beat at the default width.
  typedef struct packed {
    logic [BEAT_W-1:0]   data;
    logic [BEAT_W/8-1:0] keep;
    logic                last;
  } beat_t;

  // Element width in bits; 0 marks an unknown type.
  function automatic int GET_TYPE_WIDTH(input type_t t);
    case (t)
      UINT32_T:         return 32;
      UINT64_T, DOUBLE: return 64;
      default:          return 0;
    endcase
  endfunction

  // Number of elements that fit in one beat of out_width bits.
  function automatic int GET_TYPE_LANES(input type_t t, input int out_width);
    int w;
    w = GET_TYPE_WIDTH(t);
    return (w == 0) ? 0 : out_width / w;
  endfunction

endpackage

// File: rtl/typed_stream_packer_axis_beat_reg.sv
// Single-entry AXI4-Stream output register. A load always wins; otherwise the
// held beat is dropped once downstream accepts it. The upstream side only
// loads when the slot is free or being popped, so a stalled beat is never
// overwritten.
module typed_stream_packer_axis_beat_reg
  import typed_stream_packer_pkg::*;
#(
  parameter int OUT_WIDTH = 512
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   load,
  input  logic [OUT_WIDTH-1:0]   load_data,
  input  logic [OUT_WIDTH/8-1:0] load_keep,
  input  logic                   load_last,
  output logic [OUT_WIDTH-1:0]   m_tdata,
  output logic [OUT_WIDTH/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready
);

  logic                   vld_p1;
  logic [OUT_WIDTH-1:0]   data_p1;
  logic [OUT_WIDTH/8-1:0] keep_p1;
  logic                   last_p1;

  // Capture a completed beat, or retire the held one when downstream takes it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      keep_p1 <= load_keep;
      last_p1 <= load_last;
    end else if (m_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_tvalid = vld_p1;
  assign m_tdata  = data_p1;
  assign m_tkeep  = keep_p1;
  assign m_tlast  = last_p1;

endmodule

// File: rtl/typed_stream_packer.sv
// Packs one typed scalar element per cycle into full-width AXI4-Stream beats.
// The element type is latched on the first element of a stream and held until
// the element carrying s_last; partial final beats are flushed with tkeep.
module typed_stream_packer
  import typed_stream_packer_pkg::*;
#(
  parameter int OUT_WIDTH = 512,
  parameter int IN_WIDTH  = 64
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [1:0]             data_type,
  input  logic [IN_WIDTH-1:0]    s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [OUT_WIDTH-1:0]   m_tdata,
  output logic [OUT_WIDTH/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   err_type
);

  localparam int KEEP_W = OUT_WIDTH / 8;
  localparam int CNT_W  = $clog2(OUT_WIDTH / 32);

  logic                 active_p0;
  logic [1:0]           lat_type_p0;
  logic                 err_p0;
  logic [CNT_W-1:0]     count_p0;
  logic [OUT_WIDTH-1:0] acc_p0;

  logic [1:0]           cur_type;
  int                   width;
  int                   lanes;
  logic                 known;
  logic                 done;
  logic                 accept;
  logic                 load;
  logic [OUT_WIDTH-1:0] word;
  logic [KEEP_W-1:0]    keep;

  // Ready follows the output slot directly, so m_tready reaches s_ready
  // combinationally; this keeps full throughput without a skid buffer.
  assign s_ready  = !m_tvalid || m_tready;
  assign accept   = s_valid && s_ready;
  assign cur_type = active_p0 ? lat_type_p0 : data_type;
  assign err_type = err_p0;

  // Merge the incoming element into its lane and decide whether the beat is done
  always_comb begin
    width = GET_TYPE_WIDTH(type_t'(cur_type));
    lanes = GET_TYPE_LANES(type_t'(cur_type), OUT_WIDTH);
    known = (width != 0);
    done  = s_last || (int'(count_p0) == lanes - 1);
    word  = acc_p0;
    keep  = '0;
    if (width == 32) begin
      word[int'(count_p0)*32 +: 32] = s_data[31:0];
    end else begin
      word[int'(count_p0)*64 +: 64] = s_data[63:0];
    end
    for (int b = 0; b < KEEP_W; b++) begin
      keep[b] = (b < (int'(count_p0) + 1) * (width / 8));
    end
    load = accept && known && done;
  end

  // Latch the element type at stream start and flag unknown types
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active_p0   <= 1'b0;
      lat_type_p0 <= 2'b00;
      err_p0      <= 1'b0;
    end else if (accept) begin
      if (!active_p0) begin
        lat_type_p0 <= data_type;
        if (!known) err_p0 <= 1'b1;
      end
      active_p0 <= !s_last;
    end
  end

  // Accumulate lanes; a completed word leaves for the output register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_p0 <= '0;
      acc_p0   <= '0;
    end else if (accept && known) begin
      if (done) begin
        count_p0 <= '0;
        acc_p0   <= '0;
      end else begin
        count_p0 <= count_p0 + 1'b1;
        acc_p0   <= word;
      end
    end
  end

  typed_stream_packer_axis_beat_reg #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_beat_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .load_data (word),
    .load_keep (keep),
    .load_last (s_last),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

endmodule
